// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared constants and sizing helpers for the IF/ID queue.
//   DEFAULT_NOP_INSTR : instruction shown to decode when the queue holds nothing
//   ptr_w(depth)      : ring pointer width, log2(depth), at least 1
//   cnt_w(depth)      : occupancy counter width, able to hold 0..depth
package if_id_queue_pkg;

   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH x WIDTH register array for the IF/ID queue.
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are not reset; occupancy tracking in the parent decides validity.
//   clk   : rising-edge clock
//   we    : write enable
//   waddr : write slot
//   wdata : write data
//   raddr : read slot
//   rdata : read data (combinational)
module if_id_queue_mem import if_id_queue_pkg::*; #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned AW   = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry circular queue of (instruction, NPC) pairs between
// fetch and decode. Show-ahead head outputs, decode stall via pop, whole-queue
// kill on redirect, NOP presentation when empty, sticky protocol error flag.
// Optional feature macro: IFQ_BYPASS_EN (empty-queue same-cycle pass-through).
//   clk, reset          : clock, synchronous active-high reset
//   push, Instruction_F,
//   NPC_F               : fetch offer
//   pop                 : decode consumes head (low = stall)
//   kill                : flush all entries
//   Instruction_D, NPC_D,
//   valid_D             : head presented to decode
//   count, full, empty  : occupancy status
//   err                 : sticky overflow/underflow error
module if_id_queue import if_id_queue_pkg::*; #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       PC_W      = 32,
   parameter int unsigned       DEPTH     = 4,
   parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(DEFAULT_NOP_INSTR),
   localparam int unsigned      PTR_W     = ptr_w(DEPTH),
   localparam int unsigned      CNT_W     = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] Instruction_F,
   input  logic [PC_W-1:0]   NPC_F,
   input  logic              pop,
   input  logic              kill,
   output logic [DATA_W-1:0] Instruction_D,
   output logic [PC_W-1:0]   NPC_D,
   output logic              valid_D,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              err
);

   logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q;
   logic             pass_through;
   logic             push_acc, pop_acc, err_set;
   logic [DATA_W+PC_W-1:0] head;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign err   = err_q;

`ifdef IFQ_BYPASS_EN
   // Empty queue with push and pop together: the entry goes straight to decode.
   assign pass_through = empty && push && pop && !kill;
`else
   assign pass_through = 1'b0;
`endif

   // push_acc means "written into storage"; a pass-through entry never is.
   assign push_acc = push && (!full || pop) && !kill && !pass_through;
   assign pop_acc  = pop && !empty && !kill;
   // A pass-through pop consumes a real instruction, so it is not an underflow.
   assign err_set  = (push && full && !pop && !kill) ||
                     (pop && empty && !kill && !pass_through);

   always_comb begin
      wp_d    = push_acc ? wp_q + PTR_W'(1) : wp_q;
      rp_d    = pop_acc  ? rp_q + PTR_W'(1) : rp_q;
      count_d = count_q;
      if (push_acc && !pop_acc) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_acc && pop_acc) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (kill) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
         end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
         end
         if (err_set) begin
            err_q <= 1'b1;
         end
      end
   end

   if_id_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W + PC_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_acc),
      .waddr (wp_q),
      .wdata ({Instruction_F, NPC_F}),
      .raddr (rp_q),
      .rdata (head)
   );

   always_comb begin
      Instruction_D = NOP_INSTR;
      NPC_D         = '0;
      valid_D       = 1'b0;
      if (!empty) begin
         Instruction_D = head[DATA_W+PC_W-1:PC_W];
         NPC_D         = head[PC_W-1:0];
         valid_D       = 1'b1;
      end
`ifdef IFQ_BYPASS_EN
      else if (push && !kill) begin
         Instruction_D = Instruction_F;
         NPC_D         = NPC_F;
         valid_D       = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: self-checking bench for if_id_queue (DEPTH=4), directed
// scenarios plus randomized traffic against a queue-based reference model.
module tb_if_id_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        push = 1'b0;
   logic [31:0] Instruction_F = '0;
   logic [31:0] NPC_F = '0;
   logic        pop = 1'b0;
   logic        kill = 1'b0;
   logic [31:0] Instruction_D;
   logic [31:0] NPC_D;
   logic        valid_D;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        err;

   int total = 0;
   int bad   = 0;

   // Reference model: a plain queue of {instr, npc} plus a sticky error bit.
   logic [63:0] mq[$];
   bit          merr = 1'b0;

   if_id_queue #(
      .DATA_W    (32),
      .PC_W      (32),
      .DEPTH     (DEPTH),
      .NOP_INSTR (NOP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .push          (push),
      .Instruction_F (Instruction_F),
      .NPC_F         (NPC_F),
      .pop           (pop),
      .kill          (kill),
      .Instruction_D (Instruction_D),
      .NPC_D         (NPC_D),
      .valid_D       (valid_D),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .err           (err)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus, advance the model at the edge, settle.
   task automatic step(input bit r, input bit p, input logic [31:0] i,
                       input logic [31:0] n, input bit o, input bit k);
      bit was_full, was_empty;
      reset = r; push = p; Instruction_F = i; NPC_F = n; pop = o; kill = k;
      @(posedge clk);
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (r) begin
         mq.delete();
         merr = 1'b0;
      end else if (k) begin
         mq.delete();
      end else begin
         if ((p && was_full && !o) || (o && was_empty)) merr = 1'b1;
         if (o && !was_empty) void'(mq.pop_front());
         if (p && (!was_full || o)) mq.push_back({i, n});
      end
      #1;
      reset = 1'b0; push = 1'b0; pop = 1'b0; kill = 1'b0;
   endtask

   task automatic test_reset();
      step(1, 0, '0, '0, 0, 0);
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
      total++; if (valid_D !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_D); end
      total++; if (Instruction_D !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", Instruction_D, NOP); end
      total++; if (NPC_D !== 32'd0) begin bad++; $display("FAIL reset_npc: got %h want 0", NPC_D); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
   endtask

   task automatic test_fill();
      for (int k = 1; k <= 4; k++) step(0, 1, 32'hAAAA_0000 + k, k, 0, 0);
      total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", count); end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
      total++; if (Instruction_D !== 32'hAAAA_0001) begin bad++; $display("FAIL fill_instr: got %h want AAAA0001", Instruction_D); end
      total++; if (NPC_D !== 32'd1) begin bad++; $display("FAIL fill_npc: got %h want 1", NPC_D); end
   endtask

   task automatic test_full_push_pop();
      for (int k = 0; k < 3; k++) begin
         step(0, 1, 32'hAAAA_0005 + k, 5 + k, 1, 0);
         total++; if (count !== 3'd4) begin bad++; $display("FAIL fpp_count[%0d]: got %0d want 4", k, count); end
         total++;
         if (Instruction_D !== 32'hAAAA_0002 + k) begin
            bad++; $display("FAIL fpp_head[%0d]: got %h want %h", k, Instruction_D, 32'hAAAA_0002 + k);
         end
         total++; if (err !== 1'b0) begin bad++; $display("FAIL fpp_err[%0d]: got %b want 0", k, err); end
      end
   endtask

   task automatic test_overflow();
      step(0, 1, 32'hDEAD_BEEF, 32'h99, 0, 0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b want 1", err); end
      total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", count); end
      total++; if (Instruction_D !== 32'hAAAA_0004) begin bad++; $display("FAIL ovf_head: got %h want AAAA0004", Instruction_D); end
      for (int k = 0; k < 5; k++) step(0, 0, '0, '0, 0, 0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", err); end
   endtask

   task automatic test_kill();
      step(1, 0, '0, '0, 0, 0);
      step(0, 1, 32'hBBBB_0001, 32'h11, 0, 0);
      step(0, 1, 32'hBBBB_0002, 32'h12, 0, 0);
      step(0, 1, 32'hBBBB_0003, 32'h13, 1, 1);
      total++; if (count !== 3'd0) begin bad++; $display("FAIL kill_count: got %0d want 0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL kill_empty: got %b want 1", empty); end
      total++; if (Instruction_D !== NOP) begin bad++; $display("FAIL kill_instr: got %h want %h", Instruction_D, NOP); end
      total++; if (valid_D !== 1'b0) begin bad++; $display("FAIL kill_valid: got %b want 0", valid_D); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL kill_err: got %b want 0", err); end
   endtask

   task automatic test_underflow_reset();
      step(0, 0, '0, '0, 1, 0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL udf_err: got %b want 1", err); end
      step(1, 0, '0, '0, 0, 0);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL udf_reset_err: got %b want 0", err); end
      total++;
      if ({count, empty, full, valid_D, Instruction_D, NPC_D} !== {3'd0, 1'b1, 1'b0, 1'b0, NOP, 32'd0}) begin
         bad++;
         $display("FAIL udf_reset_outs: got cnt=%0d e=%b f=%b v=%b i=%h n=%h want cnt=0 e=1 f=0 v=0 i=%h n=0",
                  count, empty, full, valid_D, Instruction_D, NPC_D, NOP);
      end
   endtask

   task automatic test_wraparound();
      step(1, 0, '0, '0, 0, 0);
      for (int k = 0; k <= 10; k++) begin
         step(0, k < 10, 32'hC0DE_0000 + k, 32'h100 + k, k > 0, 0);
         total++; if (count > 3'd2) begin bad++; $display("FAIL wrap_count[%0d]: got %0d want <=2", k, count); end
         if (k < 10) begin
            total++;
            if (Instruction_D !== 32'hC0DE_0000 + k || NPC_D !== 32'h100 + k) begin
               bad++; $display("FAIL wrap_head[%0d]: got %h/%h want %h/%h", k, Instruction_D, NPC_D,
                               32'hC0DE_0000 + k, 32'h100 + k);
            end
         end else begin
            total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_drain: got empty=%b want 1", empty); end
         end
      end
   endtask

`ifdef IFQ_BYPASS_EN
   task automatic test_bypass();
      step(1, 0, '0, '0, 0, 0);
      push = 1'b1; Instruction_F = 32'hCCCC_0000; NPC_F = 32'h55; pop = 1'b1;
      #1;
      total++; if (Instruction_D !== 32'hCCCC_0000) begin bad++; $display("FAIL bypass_instr: got %h want CCCC0000", Instruction_D); end
      total++; if (valid_D !== 1'b1) begin bad++; $display("FAIL bypass_valid: got %b want 1", valid_D); end
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL bypass_count: got %0d want 0", count); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] ei, en;
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
         ei = (mq.size() != 0) ? mq[0][63:32] : NOP;
         en = (mq.size() != 0) ? mq[0][31:0] : 32'd0;
         total++;
         if (Instruction_D !== ei || NPC_D !== en || valid_D !== (mq.size() != 0)) begin
            bad++; $display("FAIL rand_head[%0d]: got %h/%h/%b want %h/%h/%b", c, Instruction_D, NPC_D,
                            valid_D, ei, en, mq.size() != 0);
         end
         total++;
         if (count !== 3'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin
            bad++; $display("FAIL rand_status[%0d]: got cnt=%0d f=%b e=%b want cnt=%0d", c, count, full,
                            empty, mq.size());
         end
         total++; if (err !== merr) begin bad++; $display("FAIL rand_err[%0d]: got %b want %b", c, err, merr); end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_push_pop();
      test_overflow();
      test_kill();
      test_underflow_reset();
      test_wraparound();
`ifdef IFQ_BYPASS_EN
      test_bypass();
`endif
      step(1, 0, '0, '0, 0, 0);
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
